// File: rtl/seq_gearbox_feeder.sv
// Sequence-driven feeder for a 64b/66b gearbox.
// A free-running sequence counter paces the gearbox: one output word per
// cycle, except for one pause cycle per period. Incoming 66-bit words (one per
// lane) are buffered in a small FIFO. When the FIFO runs dry, IDLE control
// blocks are inserted and counted.

// Per-lane output register: holds its value across pause cycles.
module seq_gearbox_feeder_lane (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [65:0] word,
    output logic [63:0] dat,
    output logic [1:0]  head
);

    // capture {header,payload} on every non-pause cycle, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            dat  <= '0;
            head <= '0;
        end else if (load) begin
            dat  <= word[63:0];
            head <= word[65:64];
        end
    end

endmodule

module seq_gearbox_feeder #(
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_LEN    = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [66*LANES-1:0]   s_dat,
    input  logic                  s_vld,
    output logic                  s_rdy,
    output logic [64*LANES-1:0]   m_dat,
    output logic [2*LANES-1:0]    m_head,
    output logic                  m_vld,
    output logic [5:0]            m_seq,
    input  logic                  idle_clr,
    output logic [15:0]           idle_cnt
);

    localparam int              AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW        = $clog2(FIFO_DEPTH + 1);
    localparam int              WW        = 66 * LANES;
    localparam logic [5:0]      SEQ_LAST  = 6'(SEQ_LEN - 1);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [65:0]     IDLE_LANE = {2'b10, 64'h0000_0000_0000_001e};

    logic [5:0]    cnt_seq;
    logic          pause;

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [WW-1:0] out_word;
    logic          idle_ins;
    logic [15:0]   idle_q;

    // The last count of each period is the gearbox pause slot.
    assign pause = (cnt_seq == SEQ_LAST);

    // Ready depends only on registered occupancy. A pop in the same cycle
    // does not open a slot, which keeps s_rdy free of any path from pause.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign s_rdy = !full;
    assign push  = s_vld && !full;
    assign pop   = !pause && !empty;

    // An IDLE is inserted only on a real output slot with nothing buffered.
    assign idle_ins = !pause && empty;

    // free-running sequence counter, 0..SEQ_LEN-1
    always_ff @(posedge clk) begin
        if (rst || pause)
            cnt_seq <= '0;
        else
            cnt_seq <= cnt_seq + 6'd1;
    end

    // FIFO storage; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_dat;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // head-of-FIFO word, or IDLE on every lane when the FIFO is empty
    always_comb begin
        out_word = mem[rd_ptr];
        if (empty)
            out_word = {LANES{IDLE_LANE}};
    end

    // Each lane owns its output register. All lanes share a single load
    // strobe, so one word always leaves on every lane in the same cycle.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        seq_gearbox_feeder_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (!pause),
            .word (out_word[66*k +: 66]),
            .dat  (m_dat[64*k +: 64]),
            .head (m_head[2*k +: 2])
        );
    end

    // Sequence tag and valid. The tag holds through the pause cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_seq <= '0;
            m_vld <= 1'b0;
        end else if (pause) begin
            m_vld <= 1'b0;
        end else begin
            m_seq <= cnt_seq;
            m_vld <= 1'b1;
        end
    end

    // Saturating idle-insertion counter. A clear beats an increment.
    always_ff @(posedge clk) begin
        if (rst || idle_clr)
            idle_q <= '0;
        else if (idle_ins && idle_q != 16'hFFFF)
            idle_q <= idle_q + 16'd1;
    end

    assign idle_cnt = idle_q;

endmodule

// File: tb/tb_seq_gearbox_feeder.sv
// Self-checking bench for seq_gearbox_feeder. It uses two instances:
// the default configuration, and a LANES=4 / FIFO_DEPTH=2 / SEQ_LEN=10
// configuration. Each instance is checked against a queue-style model.
module tb_seq_gearbox_feeder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance 0: defaults
    logic [65:0]  s_dat0;
    logic         s_vld0, s_rdy0, idle_clr0, m_vld0;
    logic [63:0]  m_dat0;
    logic [1:0]   m_head0;
    logic [5:0]   m_seq0;
    logic [15:0]  idle_cnt0;

    // instance 1: four lanes, shallow FIFO, short period
    logic [263:0] s_dat1;
    logic         s_vld1, s_rdy1, idle_clr1, m_vld1;
    logic [255:0] m_dat1;
    logic [7:0]   m_head1;
    logic [5:0]   m_seq1;
    logic [15:0]  idle_cnt1;

    seq_gearbox_feeder dut0 (
        .clk(clk), .rst(rst), .s_dat(s_dat0), .s_vld(s_vld0), .s_rdy(s_rdy0),
        .m_dat(m_dat0), .m_head(m_head0), .m_vld(m_vld0), .m_seq(m_seq0),
        .idle_clr(idle_clr0), .idle_cnt(idle_cnt0));

    seq_gearbox_feeder #(.LANES(4), .FIFO_DEPTH(2), .SEQ_LEN(10)) dut1 (
        .clk(clk), .rst(rst), .s_dat(s_dat1), .s_vld(s_vld1), .s_rdy(s_rdy1),
        .m_dat(m_dat1), .m_head(m_head1), .m_vld(m_vld1), .m_seq(m_seq1),
        .idle_clr(idle_clr1), .idle_cnt(idle_cnt1));

    logic [89:0]  obs0;
    logic [287:0] obs1;
    assign obs0 = {m_vld0, m_seq0, m_head0, m_dat0, s_rdy0, idle_cnt0};
    assign obs1 = {m_vld1, m_seq1, m_head1, m_dat1, s_rdy1, idle_cnt1};

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    int           sl [2] = '{33, 10};
    int           dp [2] = '{4, 2};
    int           ln [2] = '{1, 4};
    int           ph [2];
    int           mn [2];
    logic [263:0] mq [2][16];
    logic [255:0] e_dat  [2];
    logic [7:0]   e_head [2];
    logic [5:0]   e_seq  [2];
    logic         e_vld  [2];
    logic [15:0]  e_idle [2];

    task automatic model_reset(input int i);
        ph[i] = 0; mn[i] = 0;
        e_dat[i] = '0; e_head[i] = '0; e_seq[i] = '0; e_vld[i] = 1'b0; e_idle[i] = '0;
    endtask

    task automatic model_step(input int i, input logic vld, input logic [263:0] w, input logic clr);
        logic [263:0] word;
        bit rdy;
        rdy = (mn[i] < dp[i]);
        if (ph[i] != sl[i] - 1) begin
            if (mn[i] > 0) begin
                word = mq[i][0];
                for (int j = 0; j < 15; j++) mq[i][j] = mq[i][j+1];
                mn[i]--;
            end else begin
                word = '0;
                for (int k = 0; k < ln[i]; k++) word[66*k +: 66] = {2'b10, 64'h1e};
                if (e_idle[i] != 16'hFFFF) e_idle[i] = e_idle[i] + 16'd1;
            end
            for (int k = 0; k < ln[i]; k++) begin
                e_dat[i][64*k +: 64] = word[66*k +: 64];
                e_head[i][2*k +: 2]  = word[66*k+64 +: 2];
            end
            e_seq[i] = 6'(ph[i]);
            e_vld[i] = 1'b1;
        end else begin
            e_vld[i] = 1'b0;
        end
        if (clr) e_idle[i] = '0;
        if (vld && rdy) begin
            mq[i][mn[i]] = w;
            mn[i]++;
        end
        ph[i] = (ph[i] + 1) % sl[i];
    endtask

    function automatic logic [89:0] exp0();
        return {e_vld[0], e_seq[0], e_head[0][1:0], e_dat[0][63:0], (mn[0] < dp[0]), e_idle[0]};
    endfunction

    function automatic logic [287:0] exp1();
        return {e_vld[1], e_seq[1], e_head[1], e_dat[1], (mn[1] < dp[1]), e_idle[1]};
    endfunction

    // advance model and DUTs by one clock; inputs are applied on the negedge
    task automatic tick();
        if (rst) begin
            model_reset(0); model_reset(1);
        end else begin
            model_step(0, s_vld0, {198'b0, s_dat0}, idle_clr0);
            model_step(1, s_vld1, s_dat1, idle_clr1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [263:0] rand_word4();
        logic [263:0] w;
        for (int k = 0; k < 4; k++) w[66*k +: 66] = {2'($urandom), $urandom, $urandom};
        return w;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if (obs0 !== {1'b0, 6'd0, 2'd0, 64'd0, 1'b1, 16'd0}) begin
            n_bad++; $display("FAIL reset0 got=%h exp=%h", obs0, {1'b0, 6'd0, 2'd0, 64'd0, 1'b1, 16'd0});
        end
        n_cmp++;
        if (obs1 !== {1'b0, 6'd0, 8'd0, 256'd0, 1'b1, 16'd0}) begin
            n_bad++; $display("FAIL reset1 got=%h", obs1);
        end
    endtask

    task automatic test_idle();
        logic [15:0] start;
        s_vld0 = 1'b0;
        start = idle_cnt0;
        for (int c = 0; c < 66; c++) begin
            tick();
            n_cmp++;
            if (obs0 !== exp0()) begin
                n_bad++; $display("FAIL idle_model cyc=%0d got=%h exp=%h", c, obs0, exp0());
            end
            if (e_vld[0]) begin
                n_cmp++;
                if ({m_head0, m_dat0} !== {2'b10, 64'h1e}) begin
                    n_bad++; $display("FAIL idle_frame cyc=%0d got=%h exp=%h", c, {m_head0, m_dat0}, {2'b10, 64'h1e});
                end
            end
        end
        n_cmp++;
        if (idle_cnt0 - start !== 16'd64) begin
            n_bad++; $display("FAIL idle_rate got=%0d exp=64", idle_cnt0 - start);
        end
    endtask

    task automatic test_stream();
        logic [63:0] pay;
        logic [15:0] idle_mark;
        bit          saw_low;
        pay = {$urandom, $urandom};
        saw_low = 1'b0;
        idle_mark = '0;
        s_vld0 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            s_dat0 = {2'b01, pay};
            if (mn[0] < dp[0]) pay = pay + 64'd1;
            tick();
            if (c == 10) idle_mark = idle_cnt0;
            if (!s_rdy0) saw_low = 1'b1;
            n_cmp++;
            if (obs0 !== exp0()) begin
                n_bad++; $display("FAIL stream cyc=%0d got=%h exp=%h", c, obs0, exp0());
            end
        end
        n_cmp++;
        if (saw_low !== 1'b1) begin
            n_bad++; $display("FAIL stream_backpressure got=%0b exp=1", saw_low);
        end
        n_cmp++;
        if (idle_cnt0 !== idle_mark) begin
            n_bad++; $display("FAIL stream_no_idle got=%0d exp=%0d", idle_cnt0, idle_mark);
        end
        s_vld0 = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) begin
            s_vld0 = 1'($urandom);
            s_dat0 = {2'($urandom), $urandom, $urandom};
            tick();
            n_cmp++;
            if (obs0 !== exp0()) begin
                n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs0, exp0());
            end
        end
        s_vld0 = 1'b0;
    endtask

    task automatic test_single_at_31();
        logic [63:0] w;
        int guard;
        w = {$urandom, $urandom};
        s_vld0 = 1'b0;
        guard = 0;
        while ((mn[0] != 0 || ph[0] != 31) && guard < 100) begin tick(); guard++; end
        n_cmp++;
        if (guard >= 100) begin
            n_bad++; $display("FAIL single_sync got=timeout exp=phase31");
        end
        s_vld0 = 1'b1; s_dat0 = {2'b01, w};
        tick();
        s_vld0 = 1'b0;
        tick();
        n_cmp++;
        if ({m_vld0, m_seq0} !== {1'b0, 6'd31}) begin
            n_bad++; $display("FAIL single_pause got=%b/%0d exp=0/31", m_vld0, m_seq0);
        end
        tick();
        n_cmp++;
        if ({m_vld0, m_seq0, m_head0, m_dat0} !== {1'b1, 6'd0, 2'b01, w}) begin
            n_bad++; $display("FAIL single_out got=%h exp=%h", {m_vld0, m_seq0, m_head0, m_dat0}, {1'b1, 6'd0, 2'b01, w});
        end
        n_cmp++;
        if (obs0 !== exp0()) begin
            n_bad++; $display("FAIL single_model got=%h exp=%h", obs0, exp0());
        end
    endtask

    task automatic test_lanes();
        for (int c = 0; c < 120; c++) begin
            s_vld1 = ($urandom_range(3) != 0);
            s_dat1 = rand_word4();
            tick();
            n_cmp++;
            if (obs1 !== exp1()) begin
                n_bad++; $display("FAIL lanes cyc=%0d seq=%0d exp_seq=%0d vld=%b exp_vld=%b", c, m_seq1, e_seq[1], m_vld1, e_vld[1]);
            end
        end
        s_vld1 = 1'b0;
    endtask

    task automatic test_rst_full();
        int guard;
        guard = 0;
        s_vld0 = 1'b1; s_vld1 = 1'b1;
        while ((mn[0] < dp[0] || mn[1] < dp[1]) && guard < 400) begin
            s_dat0 = {2'b01, $urandom, $urandom};
            s_dat1 = rand_word4();
            tick();
            guard++;
        end
        n_cmp++;
        if (s_rdy0 !== 1'b0 || s_rdy1 !== 1'b0) begin
            n_bad++; $display("FAIL fill_full got=%b%b exp=00", s_rdy0, s_rdy1);
        end
        s_vld0 = 1'b0; s_vld1 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (obs0 !== {1'b0, 6'd0, 2'd0, 64'd0, 1'b1, 16'd0}) begin
            n_bad++; $display("FAIL rst_full0 got=%h", obs0);
        end
        n_cmp++;
        if (obs1 !== {1'b0, 6'd0, 8'd0, 256'd0, 1'b1, 16'd0}) begin
            n_bad++; $display("FAIL rst_full1 got=%h", obs1);
        end
        tick();
        n_cmp++;
        if ({m_vld0, m_seq0, m_head0, m_dat0} !== {1'b1, 6'd0, 2'b10, 64'h1e}) begin
            n_bad++; $display("FAIL rst_first_out got=%h exp=%h", {m_vld0, m_seq0, m_head0, m_dat0}, {1'b1, 6'd0, 2'b10, 64'h1e});
        end
        for (int c = 0; c < 14; c++) begin
            tick();
            n_cmp++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                n_bad++; $display("FAIL rst_flush cyc=%0d got=%h exp=%h", c, obs0, exp0());
            end
        end
    endtask

    task automatic test_idle_sat();
        s_vld0 = 1'b0;
        force dut0.idle_q = 16'hFFFC;
        #1;
        release dut0.idle_q;
        e_idle[0] = 16'hFFFC;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (obs0 !== exp0()) begin
                n_bad++; $display("FAIL sat_model cyc=%0d got=%h exp=%h", c, obs0, exp0());
            end
        end
        n_cmp++;
        if (idle_cnt0 !== 16'hFFFF) begin
            n_bad++; $display("FAIL sat_value got=%h exp=ffff", idle_cnt0);
        end
        while (ph[0] == sl[0] - 1) tick();
        idle_clr0 = 1'b1;
        tick();
        idle_clr0 = 1'b0;
        n_cmp++;
        if (idle_cnt0 !== 16'h0000) begin
            n_bad++; $display("FAIL clr_wins got=%h exp=0000", idle_cnt0);
        end
        tick();
        n_cmp++;
        if (obs0 !== exp0()) begin
            n_bad++; $display("FAIL clr_after got=%h exp=%h", obs0, exp0());
        end
    endtask

    initial begin
        rst = 1'b1;
        s_dat0 = '0; s_vld0 = 1'b0; idle_clr0 = 1'b0;
        s_dat1 = '0; s_vld1 = 1'b0; idle_clr1 = 1'b0;
        model_reset(0); model_reset(1);
        @(negedge clk);
        test_reset();
        test_idle();
        test_stream();
        test_random();
        test_single_at_31();
        test_lanes();
        test_rst_full();
        test_idle_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
